// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch program-counter sequencer.
//   Produces the fetch address each cycle. After reset it spends one cycle in
//   BOOT, then runs: traps beat redirects, redirects beat sequential steps,
//   and a stalled fetch stage holds pc. A redirect to an address that is not
//   STEP-aligned halts the sequencer until a trap restarts it.
// Parameters:
//   XLEN         - pc width in bits
//   RESET_VECTOR - first fetch address after reset
//   STEP         - sequential increment in bytes (4 or 2)
// Ports:
//   clk, rst                        - rising-edge clock, synchronous active-high reset
//   fetch_ready                     - fetch stage accepts the current pc
//   redirect_valid, redirect_target - taken branch / jump request
//   trap_valid, trap_target         - trap redirect request (low bits dropped)
//   pc, pc_valid                    - registered fetch address and its valid flag
//   pc_plus_step, wrap              - pc + STEP and its carry out, combinational
//   misaligned                      - registered, high while halted
module pc_sequencer #(
    parameter int unsigned       XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
    parameter int unsigned       STEP         = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus_step,
    output logic            pc_valid,
    output logic            wrap,
    output logic            misaligned
);

    localparam logic [XLEN-1:0] STEP_W   = XLEN'(STEP);
    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(STEP - 1);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } state_t;

    state_t          state;
    logic [XLEN:0]   step_sum;
    logic [XLEN-1:0] trap_aligned;
    logic            redirect_aligned;

    // One extra bit on the adder captures the carry out as wrap.
    assign step_sum         = {1'b0, pc} + {1'b0, STEP_W};
    assign pc_plus_step     = step_sum[XLEN-1:0];
    assign wrap             = step_sum[XLEN];

    assign trap_aligned     = trap_target & ~LOW_MASK;
    assign redirect_aligned = (redirect_target & LOW_MASK) == '0;

    // pc_valid and misaligned are registered alongside state so they always
    // reflect the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BOOT;
            pc         <= RESET_VECTOR;
            pc_valid   <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state    <= RUN;
                    pc_valid <= 1'b1;
                end
                RUN: begin
                    if (trap_valid) begin
                        pc <= trap_aligned;
                    end else if (redirect_valid) begin
                        if (redirect_aligned) begin
                            pc <= redirect_target;
                        end else begin
                            state      <= HALT;
                            pc_valid   <= 1'b0;
                            misaligned <= 1'b1;
                        end
                    end else if (fetch_ready) begin
                        pc <= pc_plus_step;
                    end
                end
                HALT: begin
                    if (trap_valid) begin
                        pc         <= trap_aligned;
                        state      <= RUN;
                        pc_valid   <= 1'b1;
                        misaligned <= 1'b0;
                    end
                end
                default: begin
                    state      <= BOOT;
                    pc_valid   <= 1'b0;
                    misaligned <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the PC width in bits.
REQ-002 The block SHALL have parameter RESET_VECTOR, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 The block SHALL have parameter STEP, default 4, giving the sequential increment in bytes; only 4 or 2 are legal.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 fetch_ready  input  1  fetch stage accepts the current pc.
REQ-007 redirect_valid  input  1  taken branch or jump request.
REQ-008 redirect_target  input  XLEN  branch or jump target address.
REQ-009 trap_valid  input  1  trap or exception redirect request.
REQ-010 trap_target  input  XLEN  trap handler address.
REQ-011 pc  output  XLEN  current fetch address, registered.
REQ-012 pc_plus_step  output  XLEN  pc + STEP, combinational from pc.
REQ-013 pc_valid  output  1  pc is a valid fetch request.
REQ-014 wrap  output  1  carry out of pc + STEP.
REQ-015 misaligned  output  1  registered; high while halted on a misaligned redirect.

Function
REQ-016 pc_plus_step SHALL equal (pc + STEP) mod 2^XLEN, and wrap SHALL be the carry out of that sum; both are combinational.
REQ-017 The FSM SHALL have exactly three states: BOOT, RUN and HALT.
REQ-018 In BOOT, pc_valid SHALL be 0 and all request inputs are ignored. The FSM moves to RUN on the next edge with pc unchanged.
REQ-019 In RUN, pc_valid SHALL be 1, and the next pc is chosen by this priority: trap, then redirect, then sequential accept, then hold.
REQ-020 RUN, trap_valid=1: pc <= trap_target with its low log2(STEP) bits forced to 0. This happens regardless of fetch_ready or redirect_valid.
REQ-021 RUN, redirect_valid=1, trap_valid=0, and redirect_target mod STEP = 0: pc <= redirect_target, regardless of fetch_ready.
REQ-022 RUN, redirect_valid=1, trap_valid=0, and redirect_target mod STEP != 0: pc holds, the FSM moves to HALT, and misaligned <= 1.
REQ-023 RUN, no request, fetch_ready=1: pc <= pc_plus_step.
REQ-024 RUN, no request, fetch_ready=0: pc and pc_valid SHALL hold (stall).
REQ-025 HALT: pc_valid SHALL be 0, pc holds, and misaligned stays 1. fetch_ready and redirect_valid are ignored.
REQ-026 HALT, trap_valid=1: pc <= aligned trap_target (per REQ-020), misaligned <= 0, and the FSM moves to RUN.
REQ-027 A sequential step from pc = 2^XLEN - STEP SHALL give pc = 0, assert wrap, and cause no halt or error.
REQ-028 A redirect to the current pc value SHALL be accepted like any other aligned redirect.

Reset
REQ-029 When rst=1 at a rising edge: state <= BOOT, pc <= RESET_VECTOR, pc_valid = 0, misaligned <= 0. pc_plus_step and wrap follow pc.
REQ-030 rst SHALL override every other input in every state, including mid-HALT and during a stall.
REQ-031 The block SHALL contain no asynchronous reset paths.

Verification
REQ-032 Reset release with fetch_ready=1 constant -> pc_valid=0 for one cycle, then pc = 0x0, 0x4, 0x8, 0xC on consecutive cycles with pc_valid=1.
REQ-033 Stall with pc=0x10 and fetch_ready=0 for 3 cycles -> pc stays 0x10 and pc_valid stays 1. Then fetch_ready=1 -> pc=0x14.
REQ-034 redirect_valid=1 (0x200) and trap_valid=1 (0x80) in the same cycle -> next pc=0x80, pc_valid=1.
REQ-035 STEP=4, redirect to 0x102 -> pc holds, pc_valid=0, misaligned=1; fetch_ready and a redirect to 0x300 are then ignored; trap to 0x1C1 -> pc=0x1C0, misaligned=0, pc_valid=1.
REQ-036 pc=0xFFFF_FFFC with fetch_ready=1 -> wrap=1 and pc_plus_step=0x0; next pc=0x0, wrap=0.
REQ-037 STEP=2 instance: redirect to 0x102 is accepted. Separately, rst during HALT -> pc=RESET_VECTOR, misaligned=0, state BOOT.
